disp_hex_mux_n: RTL



---
 rtl/disp_hex_mux_n.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/disp_hex_mux_n.sv
// -----------------------------------------------------------------------------
// disp_hex_mux_n
//
// Time-multiplexed seven-segment driver for N_DIGITS hex digits on a
// common-anode display. One digit is enabled per slot of 2^SLOT_BITS clocks.
// Features: per-digit blanking, per-digit blinking, 16-level PWM brightness
// and a frame snapshot so that a scan never mixes old and new input values.
//
// Optional feature macro:
//   DISP_LZ_BLANK_EN  - when defined, leading zeros are suppressed (a digit
//                       k > 0 is dark when it and every higher digit hold 0
//                       and its own decimal point is off; digit 0 is never
//                       suppressed).
//
// Parameters:
//   N_DIGITS   - number of digits, 2..16 (non-powers of two allowed)
//   SLOT_BITS  - each digit slot lasts 2^SLOT_BITS clocks (>= 5)
//   BLINK_BITS - blink period is 2^BLINK_BITS clocks, 50% duty
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   hex_in      in   4*N_DIGITS, digit k is hex_in[4k+3:4k]
//   dp_in       in   N_DIGITS, 1 = decimal point k lit
//   blank_in    in   N_DIGITS, 1 = digit k fully dark
//   blink_in    in   N_DIGITS, 1 = digit k blinks
//   bright      in   4, brightness level 0..15 (15 = always on)
//   frame_start out  one-cycle pulse when a snapshot is taken
//   an          out  N_DIGITS digit enables, active low, at most one low
//   sseg        out  8 segments, active low, sseg[6]=a .. sseg[0]=g, sseg[7]=dp
// -----------------------------------------------------------------------------
module disp_hex_mux_n #(
   parameter int N_DIGITS   = 8,
   parameter int SLOT_BITS  = 16,
   parameter int BLINK_BITS = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*N_DIGITS-1:0] hex_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blank_in,
   input  logic [N_DIGITS-1:0]   blink_in,
   input  logic [3:0]            bright,
   output logic                  frame_start,
   output logic [N_DIGITS-1:0]   an,
   output logic [7:0]            sseg
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_DIG = IDX_W'(N_DIGITS - 1);

   // Hex nibble to active-low segments a..g (bit 6 = a, bit 0 = g).
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   logic [SLOT_BITS-1:0]  slot_cnt;
   logic [IDX_W-1:0]      dig_idx;
   logic [BLINK_BITS-1:0] blink_cnt;

   logic [4*N_DIGITS-1:0] hex_sh;
   logic [N_DIGITS-1:0]   dp_sh;
   logic [N_DIGITS-1:0]   blank_sh;
   logic [N_DIGITS-1:0]   blink_sh;
   logic [3:0]            bright_sh;

   logic                  slot_end;
   logic                  snap;
   logic                  pwm_on;
   logic                  blink_phase;
   logic [3:0]            cur_hex;
   logic                  dig_dark;
   logic [N_DIGITS-1:0]   lz_dark;
   logic [N_DIGITS-1:0]   an_next;
   logic [7:0]            sseg_next;

   assign slot_end    = &slot_cnt;
   assign snap        = slot_end && (dig_idx == LAST_DIG);
   assign blink_phase = blink_cnt[BLINK_BITS-1];
   // Brightness compares the top nibble of the slot counter: bright+1 of the
   // 16 sub-slots are lit, so bright=15 is always on and bright=0 is 1/16.
   assign pwm_on      = (slot_cnt[SLOT_BITS-1 -: 4] <= bright_sh);

   // Scan counters. dig_idx wraps explicitly so non-power-of-two digit
   // counts never produce an out-of-range index or a dead slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_cnt  <= '0;
         dig_idx   <= '0;
         blink_cnt <= '0;
      end else begin
         slot_cnt  <= slot_cnt + 1'b1;
         blink_cnt <= blink_cnt + 1'b1;
         if (slot_end) begin
            dig_idx <= (dig_idx == LAST_DIG) ? '0 : dig_idx + 1'b1;
         end
      end
   end

   // Shadow registers load once per frame, on the last clock of the last
   // digit, so the whole next scan shows one consistent set of inputs.
   // blank resets to all ones to keep the display dark until the first frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hex_sh    <= '0;
         dp_sh     <= '0;
         blank_sh  <= '1;
         blink_sh  <= '0;
         bright_sh <= '0;
      end else if (snap) begin
         hex_sh    <= hex_in;
         dp_sh     <= dp_in;
         blank_sh  <= blank_in;
         blink_sh  <= blink_in;
         bright_sh <= bright;
      end
   end

`ifdef DISP_LZ_BLANK_EN
   logic zero_above;
   logic nib_zero;

   // Walk from the most significant digit down; a digit is a leading zero
   // while every digit above it (and itself) is zero. Its own lit dp stops
   // the suppression for that digit only.
   always_comb begin
      lz_dark    = '0;
      zero_above = 1'b1;
      nib_zero   = 1'b0;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         nib_zero   = (hex_sh[4*k +: 4] == 4'h0);
         lz_dark[k] = zero_above & nib_zero & ~dp_sh[k];
         zero_above = zero_above & nib_zero;
      end
   end
`else
   assign lz_dark = '0;
`endif

   assign cur_hex = hex_sh[4*dig_idx +: 4];

   assign dig_dark = blank_sh[dig_idx]
                   | (blink_sh[dig_idx] & blink_phase)
                   | ~pwm_on
                   | lz_dark[dig_idx];

   always_comb begin
      an_next   = '1;
      sseg_next = 8'hFF;
      if (!dig_dark) begin
         an_next[dig_idx] = 1'b0;
         sseg_next        = {~dp_sh[dig_idx], hex_to_seg(cur_hex)};
      end
   end

   // Output register: an and sseg update in the same edge so a digit switch
   // never shows the previous digit's segments on the new anode.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an          <= '1;
         sseg        <= 8'hFF;
         frame_start <= 1'b0;
      end else begin
         an          <= an_next;
         sseg        <= sseg_next;
         frame_start <= snap;
      end
   end

endmodule
